parking_gate_sequencer: RTL and testbench
=========================================

# parking_gate_sequencer

Gate-side request sequencer that drives the stimulus interface of `parking_lot_top`. It buffers car arrival and departure requests from the entrance/exit gates in a small FIFO. It issues them to the lot one at a time as single-cycle `in_mode`/`out_mode` pulses with the BCD plate, and tracks the lot's `moving` bus to detect completion. It then reports each transaction, with the lot's fee, back to the gate controller, and forwards leakage alarms as single-cycle pulses.

## Interface
- `DEPTH`, 4: request FIFO entries (power of two, ≥2).
- `TIMEOUT`, 63: max cycles spent in a wait state before abort (fits 8 bits).

- `clock`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low (0 = reset).
- `req_valid`  input  1  gate request present.
- `req_ready`  output  1  FIFO can accept; `= !full`.
- `req_plate`  input  16  4-digit BCD plate.
- `req_dir`  input  1  0 = park (in), 1 = retrieve (out).
- `req_err`  output  1  one-cycle pulse: request rejected as malformed.
- `pending`  output  clog2(DEPTH)+1  FIFO occupancy.
- `license_plate`  output  16  plate to lot; 0 when no mode pulse.
- `in_mode`  output  1  one-cycle park command.
- `out_mode`  output  1  one-cycle retrieve command.
- `lot_moving`  input  16  lot's `moving` bus (plate in elevator, 0 = empty).
- `lot_fee`  input  8  lot's `fee` output.
- `leak_req`  input  1  leakage alarm from sensor (level or pulse).
- `leak_floor_in`  input  3  floor of alarm, 1–7.
- `leakage`  output  1  one-cycle leakage command.
- `leakage_floor`  output  3  floor to lot; 0 when `leakage` low.
- `done_valid`  output  1  one-cycle transaction report.
- `done_plate`  output  16  plate of reported transaction.
- `done_fee`  output  8  `lot_fee` sampled on completion (0 for in or timeout).
- `done_timeout`  output  1  report is an abort.

## Operation
- Reset: all outputs 0, except `req_ready` = 1. FIFO empty, FSM in IDLE, counter 0.
- Accept on edge with `req_valid & req_ready`. Reject if any nibble >9 or plate = 0. A rejected request is not stored and drives `req_err` for 1 cycle. `req_ready` is unaffected by a rejection.
- FSM states: IDLE, ISSUE, WAIT_ON, WAIT_OFF, REPORT.
- IDLE: if FIFO is non-empty, pop the head into a plate/dir register and go to ISSUE.
- ISSUE (1 cycle): drive `license_plate` = plate and `in_mode` = !dir / `out_mode` = dir. Go to WAIT_ON.
- WAIT_ON: go to WAIT_OFF when `lot_moving == plate`.
- WAIT_OFF: go to REPORT when `lot_moving == 0`. Sample `lot_fee` in that same cycle if dir = out.
- REPORT (1 cycle): drive `done_valid`, `done_plate`, `done_fee`, `done_timeout`. Go to IDLE.
- Timeout:
  - The counter clears on entry to WAIT_ON and increments each cycle in WAIT_ON/WAIT_OFF.
  - At count == TIMEOUT, go to REPORT with `done_timeout` = 1 and `done_fee` = 0.
- Leakage:
  - Rising edge of `leak_req` produces `leakage` = 1 and `leakage_floor` = `leak_floor_in` on the next cycle, independent of FSM state.
  - `leak_floor_in` of 0 is ignored (no pulse).
  - A held-high `leak_req` gives one pulse only.
- Simultaneous push and pop in IDLE are both honoured; occupancy is unchanged.
- Mode outputs are never asserted outside ISSUE. At most one of `in_mode`/`out_mode` is high at a time.

## Timing
- All outputs are registered.
- Request accepted at edge k, FIFO previously empty, FSM IDLE:
  - pop at edge k+1;
  - `in_mode`/`out_mode` high from edge k+2 to k+3.
- Issue to issue: minimum 4 cycles plus the lot's response time. Back-to-back requests are separated by at least REPORT + IDLE.
- `done_valid` rises one edge after the cycle in which `lot_moving` returns to 0.
- `req_err` rises one edge after the rejecting accept edge.
- Full FIFO: `req_ready` = 0 in the same cycle `pending == DEPTH`. It rises the edge after a pop.
- Reset asserted mid-transaction: immediate return to reset values. The FIFO is flushed and no `done_valid` is issued for the in-flight request.
- FIFO pointers wrap modulo DEPTH. `pending` never exceeds DEPTH.

## Test plan
- Reset with `reset` = 0 → all outputs 0 and `req_ready` = 1. Release, then push 9423/in at edge k → `in_mode` = 1 and `license_plate` = 0x9423 exactly during cycle k+2. Model `lot_moving` = 0x9423 for 3 cycles, then 0 → `done_valid` with plate 0x9423, fee 0, timeout 0.
- Push 9423/in, 8754/in, 8754/out back-to-back → three mode pulses in order, never overlapping. Second pulse only after the first `done_valid`. For 8754/out with `lot_fee` = 25 at completion → `done_fee` = 25.
- Push DEPTH+1 requests while the lot model never responds → `req_ready` low once `pending` = 4. The first request times out after 63 cycles in WAIT_ON with `done_timeout` = 1. Then `req_ready` rises again.
- Push plate 0x9A23 and plate 0x0000 → `req_err` pulses twice, `pending` stays 0, and no mode pulse occurs.
- `leak_req` held high for 5 cycles with floor 3, during WAIT_OFF → exactly one `leakage` pulse with `leakage_floor` = 3. Transaction completes normally.
- Assert `reset` during WAIT_ON with 2 entries queued → `pending` = 0 and no `done_valid`. After release, no mode pulses occur.

Source files
------------

// File: rtl/parking_gate_sequencer.sv
// parking_gate_sequencer: buffers gate park/retrieve requests in a small FIFO,
// issues them to the lot one at a time and reports each completion (or abort)
// back to the gate controller. Leakage alarms are forwarded as single pulses.
module parking_gate_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [15:0]              req_plate,
  input  logic                     req_dir,
  output logic                     req_err,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [15:0]              license_plate,
  output logic                     in_mode,
  output logic                     out_mode,
  input  logic [15:0]              lot_moving,
  input  logic [7:0]               lot_fee,
  input  logic                     leak_req,
  input  logic [2:0]               leak_floor_in,
  output logic                     leakage,
  output logic [2:0]               leakage_floor,
  output logic                     done_valid,
  output logic [15:0]              done_plate,
  output logic [7:0]               done_fee,
  output logic                     done_timeout
);

  localparam int              PW            = $clog2(DEPTH);
  localparam logic [PW:0]     FULL_COUNT    = (PW+1)'(DEPTH);
  localparam logic [7:0]      TIMEOUT_COUNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ON, WAIT_OFF, REPORT} state_t;

  state_t        state;
  state_t        next_state;
  logic [16:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [15:0]   cur_plate;
  logic          cur_dir;
  logic [7:0]    wait_count;
  logic          leak_req_d;
  logic          plate_ok;
  logic          push;
  logic          reject;
  logic          pop;
  logic          to_report;
  logic          timed_out;
  logic          leak_fire;

  assign req_ready = (count != FULL_COUNT);
  assign pending   = count;
  assign push      = req_valid && req_ready && plate_ok;
  assign reject    = req_valid && req_ready && !plate_ok;
  assign pop       = (state == IDLE) && (count != '0);
  assign leak_fire = leak_req && !leak_req_d && (leak_floor_in != 3'd0);

  // A plate is well-formed only if it is non-zero and every nibble is a decimal digit.
  always_comb begin
    plate_ok = (req_plate != 16'h0000);
    for (int i = 0; i < 4; i++) begin
      if (req_plate[i*4 +: 4] > 4'd9) plate_ok = 1'b0;
    end
  end

  // Request storage; entries are only meaningful between the pointers, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {req_dir, req_plate};
  end

  // FIFO pointers wrap naturally at DEPTH; occupancy holds when push and pop coincide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; an expired wait counter takes priority over lot progress.
  always_comb begin
    next_state = state;
    to_report  = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE:     if (count != '0) next_state = ISSUE;
      ISSUE:    next_state = WAIT_ON;
      WAIT_ON: begin
        if (wait_count == TIMEOUT_COUNT) begin
          next_state = REPORT;
          to_report  = 1'b1;
          timed_out  = 1'b1;
        end else if (lot_moving == cur_plate) begin
          next_state = WAIT_OFF;
        end
      end
      WAIT_OFF: begin
        if (wait_count == TIMEOUT_COUNT) begin
          next_state = REPORT;
          to_report  = 1'b1;
          timed_out  = 1'b1;
        end else if (lot_moving == 16'h0000) begin
          next_state = REPORT;
          to_report  = 1'b1;
        end
      end
      REPORT:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Current transaction register and the wait-state watchdog counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_plate  <= '0;
      cur_dir    <= 1'b0;
      wait_count <= '0;
    end else begin
      if (pop) {cur_dir, cur_plate} <= fifo_mem[rd_ptr];
      if (state == ISSUE)
        wait_count <= '0;
      else if ((state == WAIT_ON) || (state == WAIT_OFF))
        wait_count <= wait_count + 1'b1;
    end
  end

  // Registered outputs: lot commands, completion report, reject flag and leakage forwarding.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_mode       <= 1'b0;
      out_mode      <= 1'b0;
      license_plate <= '0;
      done_valid    <= 1'b0;
      done_plate    <= '0;
      done_fee      <= '0;
      done_timeout  <= 1'b0;
      req_err       <= 1'b0;
      leak_req_d    <= 1'b0;
      leakage       <= 1'b0;
      leakage_floor <= '0;
    end else begin
      in_mode       <= (state == ISSUE) && !cur_dir;
      out_mode      <= (state == ISSUE) && cur_dir;
      license_plate <= (state == ISSUE) ? cur_plate : 16'h0000;
      done_valid    <= to_report;
      done_plate    <= to_report ? cur_plate : 16'h0000;
      done_fee      <= (to_report && !timed_out && cur_dir) ? lot_fee : 8'h00;
      done_timeout  <= timed_out;
      req_err       <= reject;
      leak_req_d    <= leak_req;
      leakage       <= leak_fire;
      leakage_floor <= leak_fire ? leak_floor_in : 3'd0;
    end
  end

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// tb_parking_gate_sequencer: scenario tasks plus a randomized run, checked against
// a transaction-level model of the gate sequencer and a simple lot responder.
module tb_parking_gate_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 63;

  typedef struct { logic [15:0] plate; logic dir; int cyc; } mode_rec_t;
  typedef struct { logic [15:0] plate; logic [7:0] fee; logic tmo; int cyc; } done_rec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_plate;
  logic        req_dir;
  logic        req_err;
  logic [2:0]  pending;
  logic [15:0] license_plate;
  logic        in_mode;
  logic        out_mode;
  logic [15:0] lot_moving;
  logic [7:0]  lot_fee;
  logic        leak_req;
  logic [2:0]  leak_floor_in;
  logic        leakage;
  logic [2:0]  leakage_floor;
  logic        done_valid;
  logic [15:0] done_plate;
  logic [7:0]  done_fee;
  logic        done_timeout;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  mode_rec_t mode_q[$];
  done_rec_t done_q[$];
  done_rec_t exp_done_q[$];
  int        err_high    = 0;
  int        leak_count  = 0;
  int        floor_err   = 0;
  int        overlap_err = 0;
  logic [2:0] leak_floor_seen = 3'd0;
  bit        outstanding = 1'b0;

  bit        lot_enable = 1'b0;
  bit        lot_random = 1'b0;
  int        lot_delay  = 0;
  int        lot_busy   = 3;
  logic [7:0] next_fee  = 8'd0;

  parking_gate_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_plate(req_plate), .req_dir(req_dir),
    .req_err(req_err), .pending(pending),
    .license_plate(license_plate), .in_mode(in_mode), .out_mode(out_mode),
    .lot_moving(lot_moving), .lot_fee(lot_fee),
    .leak_req(leak_req), .leak_floor_in(leak_floor_in),
    .leakage(leakage), .leakage_floor(leakage_floor),
    .done_valid(done_valid), .done_plate(done_plate), .done_fee(done_fee), .done_timeout(done_timeout)
  );

  // Free-running clock and a cycle counter used to timestamp observed events.
  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Watchdog so the run always ends even if something stalls unexpectedly.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Passive monitor recording every command, report and pulse seen on the outputs.
  always @(negedge clock) begin
    mode_rec_t m;
    done_rec_t d;
    if (!reset) outstanding = 1'b0;
    if (in_mode && out_mode) overlap_err++;
    if (in_mode || out_mode) begin
      if (outstanding) overlap_err++;
      outstanding = 1'b1;
      m.plate = license_plate; m.dir = out_mode; m.cyc = cyc;
      mode_q.push_back(m);
    end
    if (done_valid) begin
      outstanding = 1'b0;
      d.plate = done_plate; d.fee = done_fee; d.tmo = done_timeout; d.cyc = cyc;
      done_q.push_back(d);
    end
    if (req_err) err_high++;
    if (leakage) begin
      leak_count++;
      leak_floor_seen = leakage_floor;
    end
    if (!leakage && (leakage_floor != 3'd0)) floor_err++;
  end

  // Behavioural lot: after a command it shows the plate in the elevator, later clears it,
  // and predicts the report the sequencer owes one cycle after the clear.
  initial begin
    logic [15:0] lp;
    logic        ld;
    int          dly;
    int          bsy;
    logic [7:0]  fee;
    done_rec_t   e;
    lot_moving = 16'h0;
    lot_fee    = 8'h0;
    forever begin
      @(negedge clock);
      if (lot_enable && (in_mode || out_mode)) begin
        lp = license_plate;
        ld = out_mode;
        if (lot_random) begin
          dly = $urandom_range(0, 2);
          bsy = $urandom_range(1, 4);
          fee = 8'($urandom_range(1, 255));
        end else begin
          dly = lot_delay;
          bsy = lot_busy;
          fee = next_fee;
        end
        repeat (dly) @(negedge clock);
        lot_moving = lp;
        repeat (bsy) @(negedge clock);
        lot_moving = 16'h0;
        lot_fee    = ld ? fee : 8'($urandom_range(0, 255));
        e.plate = lp; e.fee = ld ? fee : 8'd0; e.tmo = 1'b0; e.cyc = cyc + 1;
        exp_done_q.push_back(e);
      end
    end
  end

  // A plate is acceptable when non-zero and each base-16 digit is below ten.
  function automatic bit model_plate_ok(input logic [15:0] p);
    int v = int'(p);
    if (v == 0) return 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((v % 16) > 9) return 1'b0;
      v = v / 16;
    end
    return 1'b1;
  endfunction

  task automatic clear_mon();
    mode_q.delete();
    done_q.delete();
    exp_done_q.delete();
    err_high = 0; leak_count = 0; floor_err = 0; overlap_err = 0; leak_floor_seen = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Presents one request for exactly one accepting edge; returns at the following negedge.
  task automatic push_req(input logic [15:0] p, input logic d);
    int t = 0;
    while (!req_ready && t < 500) begin @(negedge clock); t++; end
    if (!req_ready) begin
      checks++;
      $display("[TB] FAIL push_wait: req_ready stayed %b, required 1", req_ready);
    end
    req_valid = 1'b1; req_plate = p; req_dir = d;
    @(negedge clock);
    req_valid = 1'b0; req_plate = 16'h0; req_dir = 1'b0;
  endtask

  task automatic wait_done(input int n, input int bound);
    int t = 0;
    while (done_q.size() < n && t < bound) begin @(negedge clock); t++; end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", req_ready); else passes++;
    checks++; if (pending !== 3'd0) $display("[TB] FAIL reset_pending: got %0d want 0", pending); else passes++;
    checks++; if ({in_mode, out_mode, done_valid, done_timeout, req_err, leakage} !== 6'b0)
      $display("[TB] FAIL reset_flags: got %b want 000000", {in_mode, out_mode, done_valid, done_timeout, req_err, leakage});
    else passes++;
    checks++; if ({license_plate, done_plate, done_fee, leakage_floor} !== 43'd0)
      $display("[TB] FAIL reset_buses: got %h want 0", {license_plate, done_plate, done_fee, leakage_floor});
    else passes++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_in();
    clear_mon();
    lot_enable = 1'b1; lot_random = 1'b0; lot_delay = 0; lot_busy = 3; next_fee = 8'd0;
    push_req(16'h9423, 1'b0);
    @(negedge clock);
    checks++; if (in_mode !== 1'b0) $display("[TB] FAIL single_early: in_mode got %b want 0 at k+1", in_mode); else passes++;
    @(negedge clock);
    checks++; if ({in_mode, out_mode} !== 2'b10) $display("[TB] FAIL single_mode: got %b want 10 at k+2", {in_mode, out_mode}); else passes++;
    checks++; if (license_plate !== 16'h9423) $display("[TB] FAIL single_plate: got %h want 9423", license_plate); else passes++;
    @(negedge clock);
    checks++; if ({in_mode, license_plate} !== 17'd0) $display("[TB] FAIL single_after: got %h want 0 at k+3", {in_mode, license_plate}); else passes++;
    wait_done(1, 60);
    checks++; if (done_q.size() !== 1) $display("[TB] FAIL single_done_count: got %0d want 1", done_q.size()); else passes++;
    if (done_q.size() >= 1 && exp_done_q.size() >= 1) begin
      checks++; if ({done_q[0].plate, done_q[0].fee, done_q[0].tmo} !== {16'h9423, 8'd0, 1'b0})
        $display("[TB] FAIL single_report: got %h/%0d/%b want 9423/0/0", done_q[0].plate, done_q[0].fee, done_q[0].tmo);
      else passes++;
      checks++; if (done_q[0].cyc !== exp_done_q[0].cyc)
        $display("[TB] FAIL single_done_time: got cycle %0d want %0d", done_q[0].cyc, exp_done_q[0].cyc);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] plates [3];
    logic        dirs   [3];
    plates[0] = 16'h9423; plates[1] = 16'h8754; plates[2] = 16'h8754;
    dirs[0] = 1'b0; dirs[1] = 1'b0; dirs[2] = 1'b1;
    clear_mon();
    lot_enable = 1'b1; lot_random = 1'b0; lot_delay = 1; lot_busy = 2; next_fee = 8'd25;
    push_req(plates[0], dirs[0]);
    push_req(plates[1], dirs[1]);
    checks++; if (pending !== 3'd1) $display("[TB] FAIL b2b_push_pop: pending got %0d want 1", pending); else passes++;
    push_req(plates[2], dirs[2]);
    checks++; if (pending !== 3'd2) $display("[TB] FAIL b2b_pending: got %0d want 2", pending); else passes++;
    wait_done(3, 200);
    checks++; if (mode_q.size() !== 3) $display("[TB] FAIL b2b_mode_count: got %0d want 3", mode_q.size()); else passes++;
    for (int i = 0; i < 3 && i < mode_q.size(); i++) begin
      checks++; if ({mode_q[i].plate, mode_q[i].dir} !== {plates[i], dirs[i]})
        $display("[TB] FAIL b2b_mode[%0d]: got %h/%b want %h/%b", i, mode_q[i].plate, mode_q[i].dir, plates[i], dirs[i]);
      else passes++;
    end
    if (mode_q.size() == 3 && done_q.size() == 3) begin
      checks++; if (!(mode_q[1].cyc > done_q[0].cyc && mode_q[2].cyc > done_q[1].cyc))
        $display("[TB] FAIL b2b_order: issue cycles %0d,%0d vs done cycles %0d,%0d", mode_q[1].cyc, mode_q[2].cyc, done_q[0].cyc, done_q[1].cyc);
      else passes++;
      checks++; if ({done_q[0].fee, done_q[1].fee, done_q[2].fee} !== {8'd0, 8'd0, 8'd25})
        $display("[TB] FAIL b2b_fees: got %0d,%0d,%0d want 0,0,25", done_q[0].fee, done_q[1].fee, done_q[2].fee);
      else passes++;
    end
    checks++; if (overlap_err !== 0) $display("[TB] FAIL b2b_overlap: got %0d want 0", overlap_err); else passes++;
  endtask

  task automatic test_full_timeout();
    int t = 0;
    clear_mon();
    lot_enable = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_req(16'h1111 * 16'(i + 1), 1'b0);
    checks++; if ({pending, req_ready} !== {3'(DEPTH), 1'b0})
      $display("[TB] FAIL full_state: got pending %0d ready %b want %0d/0", pending, req_ready, DEPTH);
    else passes++;
    wait_done(1, 200);
    checks++; if (done_q.size() !== 1) $display("[TB] FAIL tmo_count: got %0d want 1", done_q.size()); else passes++;
    if (done_q.size() >= 1 && mode_q.size() >= 1) begin
      checks++; if ({done_q[0].plate, done_q[0].fee, done_q[0].tmo} !== {16'h1111, 8'd0, 1'b1})
        $display("[TB] FAIL tmo_report: got %h/%0d/%b want 1111/0/1", done_q[0].plate, done_q[0].fee, done_q[0].tmo);
      else passes++;
      checks++; if ((done_q[0].cyc - mode_q[0].cyc) < TIMEOUT || (done_q[0].cyc - mode_q[0].cyc) > TIMEOUT + 2)
        $display("[TB] FAIL tmo_latency: got %0d cycles want %0d..%0d", done_q[0].cyc - mode_q[0].cyc, TIMEOUT, TIMEOUT + 2);
      else passes++;
    end
    while (!req_ready && t < 6) begin @(negedge clock); t++; end
    checks++; if ({req_ready, pending} !== {1'b1, 3'(DEPTH - 1)})
      $display("[TB] FAIL tmo_ready: got ready %b pending %0d want 1/%0d", req_ready, pending, DEPTH - 1);
    else passes++;
    do_reset();
  endtask

  task automatic test_reject();
    clear_mon();
    push_req(16'h9A23, 1'b0);
    @(negedge clock);
    push_req(16'h0000, 1'b1);
    repeat (10) @(negedge clock);
    checks++; if (err_high !== 2) $display("[TB] FAIL reject_pulses: got %0d want 2", err_high); else passes++;
    checks++; if (pending !== 3'd0) $display("[TB] FAIL reject_pending: got %0d want 0", pending); else passes++;
    checks++; if (mode_q.size() !== 0) $display("[TB] FAIL reject_modes: got %0d want 0", mode_q.size()); else passes++;
  endtask

  task automatic test_leakage();
    int t = 0;
    clear_mon();
    lot_enable = 1'b1; lot_random = 1'b0; lot_delay = 0; lot_busy = 8; next_fee = 8'd0;
    push_req(16'h1234, 1'b0);
    while (lot_moving == 16'h0 && t < 20) begin @(negedge clock); t++; end
    @(negedge clock);
    leak_req = 1'b1; leak_floor_in = 3'd3;
    repeat (5) @(negedge clock);
    leak_req = 1'b0; leak_floor_in = 3'd0;
    wait_done(1, 60);
    checks++; if ({leak_count, leak_floor_seen} !== {32'd1, 3'd3})
      $display("[TB] FAIL leak_pulse: got %0d pulses floor %0d want 1/3", leak_count, leak_floor_seen);
    else passes++;
    checks++; if (done_q.size() !== 1) $display("[TB] FAIL leak_done_count: got %0d want 1", done_q.size()); else passes++;
    if (done_q.size() >= 1) begin
      checks++; if ({done_q[0].plate, done_q[0].tmo} !== {16'h1234, 1'b0})
        $display("[TB] FAIL leak_done: got %h/%b want 1234/0", done_q[0].plate, done_q[0].tmo);
      else passes++;
    end
    leak_req = 1'b1; leak_floor_in = 3'd0;
    repeat (3) @(negedge clock);
    leak_req = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (leak_count !== 1) $display("[TB] FAIL leak_floor0: got %0d pulses want 1", leak_count); else passes++;
    checks++; if (floor_err !== 0) $display("[TB] FAIL leak_floor_idle: got %0d want 0", floor_err); else passes++;
  endtask

  task automatic test_reset_in_flight();
    clear_mon();
    lot_enable = 1'b0;
    push_req(16'h2222, 1'b0);
    push_req(16'h3333, 1'b1);
    push_req(16'h4444, 1'b0);
    repeat (4) @(negedge clock);
    checks++; if (pending !== 3'd2) $display("[TB] FAIL rif_pending_pre: got %0d want 2", pending); else passes++;
    clear_mon();
    reset = 1'b0;
    #1;
    checks++; if ({pending, req_ready, done_valid, in_mode, out_mode} !== {3'd0, 1'b1, 3'b000})
      $display("[TB] FAIL rif_immediate: got %b want 0001000", {pending, req_ready, done_valid, in_mode, out_mode});
    else passes++;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    checks++; if ({mode_q.size(), done_q.size()} !== 64'd0)
      $display("[TB] FAIL rif_quiet: got %0d modes %0d reports want 0/0", mode_q.size(), done_q.size());
    else passes++;
  endtask

  task automatic test_random();
    mode_rec_t   exp_q[$];
    mode_rec_t   m;
    logic [15:0] p;
    logic        d;
    int          err_exp = 0;
    clear_mon();
    lot_enable = 1'b1; lot_random = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        p = 16'($urandom_range(0, 9) * 4096 + $urandom_range(0, 9) * 256 + $urandom_range(0, 9) * 16 + $urandom_range(1, 9));
      end else begin
        p = 16'($urandom);
      end
      d = 1'($urandom_range(0, 1));
      if (model_plate_ok(p)) begin
        m.plate = p; m.dir = d; m.cyc = 0;
        exp_q.push_back(m);
      end else begin
        err_exp++;
      end
      push_req(p, d);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_done(exp_q.size(), 3000);
    @(negedge clock);
    checks++; if (mode_q.size() !== exp_q.size()) $display("[TB] FAIL rand_mode_count: got %0d want %0d", mode_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < mode_q.size(); i++) begin
      checks++; if ({mode_q[i].plate, mode_q[i].dir} !== {exp_q[i].plate, exp_q[i].dir})
        $display("[TB] FAIL rand_mode[%0d]: got %h/%b want %h/%b", i, mode_q[i].plate, mode_q[i].dir, exp_q[i].plate, exp_q[i].dir);
      else passes++;
    end
    checks++; if (done_q.size() !== exp_done_q.size()) $display("[TB] FAIL rand_done_count: got %0d want %0d", done_q.size(), exp_done_q.size()); else passes++;
    for (int i = 0; i < exp_done_q.size() && i < done_q.size(); i++) begin
      checks++; if ({done_q[i].plate, done_q[i].fee, done_q[i].tmo, done_q[i].cyc} !== {exp_done_q[i].plate, exp_done_q[i].fee, exp_done_q[i].tmo, exp_done_q[i].cyc})
        $display("[TB] FAIL rand_done[%0d]: got %h/%0d/%b@%0d want %h/%0d/%b@%0d", i, done_q[i].plate, done_q[i].fee, done_q[i].tmo, done_q[i].cyc,
                 exp_done_q[i].plate, exp_done_q[i].fee, exp_done_q[i].tmo, exp_done_q[i].cyc);
      else passes++;
    end
    checks++; if (err_high !== err_exp) $display("[TB] FAIL rand_errs: got %0d want %0d", err_high, err_exp); else passes++;
    checks++; if (overlap_err !== 0) $display("[TB] FAIL rand_overlap: got %0d want 0", overlap_err); else passes++;
    lot_random = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    reset = 1'b0; req_valid = 1'b0; req_plate = 16'h0; req_dir = 1'b0;
    leak_req = 1'b0; leak_floor_in = 3'd0;
    test_reset();
    test_single_in();
    test_back_to_back();
    test_full_timeout();
    test_reject();
    test_leakage();
    test_reset_in_flight();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
